// File: rtl/mpi_axil_master.sv
// mpi_axil_master: AXI4-Lite slave that turns one access at a time into an MPI register-bus write or read.
// Optional feature MPI_ADDR_RANGE_CHECK_EN: accesses with byte-address bits above the MPI space are
// answered with SLVERR and never reach the register bus; without it those bits alias onto the MPI space.
module mpi_axil_master #(
    parameter int CPU_ADDR_WIDTH = 12,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RD_LAT         = 2
) (
    input  logic                      clks,
    input  logic                      reset_n,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [CPU_DATA_WIDTH-1:0] s_wdata,
    input  logic [3:0]                s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [CPU_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      cpu_wr,
    output logic                      cpu_rd,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out
);
    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

`ifdef MPI_ADDR_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif
    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

    state_t                    state, state_n;
    logic                      aw_rdy_n, ar_rdy_n, bvalid_n, rvalid_n, wr_n, rd_n;
    logic                      err, err_n, last_rd, last_rd_n;
    logic [1:0]                bresp_n, rresp_n;
    logic [CPU_DATA_WIDTH-1:0] rdata_n, wdata_n;
    logic [CPU_ADDR_WIDTH-1:0] addr_n;
    logic [3:0]                cnt, cnt_n;
    logic                      wr_pend, pick_rd, aw_err, ar_err, wr_ok;

    // AW and W are always accepted together, so one register drives both readies.
    assign s_wready = s_awready;
    assign wr_pend  = s_awvalid && s_wvalid;
    // On a conflict serve the type not served last; last_rd resets to "write" so a read wins first.
    assign pick_rd  = s_arvalid && (!wr_pend || !last_rd);
    assign aw_err   = RANGE_CHK && ((s_awaddr >> (CPU_ADDR_WIDTH + 2)) != '0);
    assign ar_err   = RANGE_CHK && ((s_araddr >> (CPU_ADDR_WIDTH + 2)) != '0);
    assign wr_ok    = (s_wstrb == 4'hF) && !aw_err;

    // Next-state and next-output decode; every output is a register loaded from these values.
    always_comb begin
        state_n   = state;
        aw_rdy_n  = 1'b0;
        ar_rdy_n  = 1'b0;
        wr_n      = 1'b0;
        rd_n      = 1'b0;
        bvalid_n  = s_bvalid;
        rvalid_n  = s_rvalid;
        bresp_n   = s_bresp;
        rresp_n   = s_rresp;
        rdata_n   = s_rdata;
        addr_n    = cpu_wr_addr;
        wdata_n   = cpu_data_in;
        cnt_n     = cnt;
        err_n     = err;
        last_rd_n = last_rd;
        case (state)
            IDLE: begin
                if (s_awready && wr_pend) begin
                    state_n   = WR_ISSUE;
                    addr_n    = CPU_ADDR_WIDTH'(s_awaddr >> 2);
                    wdata_n   = s_wdata;
                    wr_n      = wr_ok;
                    bresp_n   = wr_ok ? 2'b00 : 2'b10;
                    last_rd_n = 1'b0;
                end else if (s_arready && s_arvalid) begin
                    state_n   = RD_ISSUE;
                    addr_n    = CPU_ADDR_WIDTH'(s_araddr >> 2);
                    rd_n      = !ar_err;
                    err_n     = ar_err;
                    last_rd_n = 1'b1;
                end else if (!s_awready && !s_arready) begin
                    ar_rdy_n = pick_rd;
                    aw_rdy_n = wr_pend && !pick_rd;
                end
            end
            WR_ISSUE: begin
                state_n  = WR_RESP;
                bvalid_n = 1'b1;
            end
            WR_RESP: begin
                if (s_bready) begin
                    state_n  = IDLE;
                    bvalid_n = 1'b0;
                end
            end
            RD_ISSUE: begin
                state_n = RD_WAIT;
                cnt_n   = WAIT_INIT;
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n  = RD_RESP;
                    rvalid_n = 1'b1;
                    rdata_n  = err ? '0 : cpu_data_out;
                    rresp_n  = err ? 2'b10 : 2'b00;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RD_RESP: begin
                if (s_rready) begin
                    state_n  = IDLE;
                    rvalid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transaction without a response.
    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            s_awready   <= 1'b0;
            s_arready   <= 1'b0;
            s_bvalid    <= 1'b0;
            s_rvalid    <= 1'b0;
            s_bresp     <= 2'b00;
            s_rresp     <= 2'b00;
            s_rdata     <= '0;
            cpu_wr      <= 1'b0;
            cpu_rd      <= 1'b0;
            cpu_wr_addr <= '0;
            cpu_data_in <= '0;
            cnt         <= 4'd0;
            err         <= 1'b0;
            last_rd     <= 1'b0;
        end else begin
            state       <= state_n;
            s_awready   <= aw_rdy_n;
            s_arready   <= ar_rdy_n;
            s_bvalid    <= bvalid_n;
            s_rvalid    <= rvalid_n;
            s_bresp     <= bresp_n;
            s_rresp     <= rresp_n;
            s_rdata     <= rdata_n;
            cpu_wr      <= wr_n;
            cpu_rd      <= rd_n;
            cpu_wr_addr <= addr_n;
            cpu_data_in <= wdata_n;
            cnt         <= cnt_n;
            err         <= err_n;
            last_rd     <= last_rd_n;
        end
    end
endmodule

// File: tb/tb_mpi_axil_master.sv
// tb_mpi_axil_master: randomized bench for mpi_axil_master with a register-file model and a reference memory.
module tb_mpi_axil_master;
    localparam int RD_LAT = 2;

    logic        clks = 1'b0, reset_n = 1'b1;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0, s_bready = 1'b0, s_rready = 1'b0;
    logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, cpu_data_in, cpu_data_out;
    logic [11:0] cpu_wr_addr;

    int n_checks = 0, n_errors = 0;

    always #5 clks = ~clks;

    mpi_axil_master #(.RD_LAT(RD_LAT)) dut (
        .clks(clks), .reset_n(reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wr_addr(cpu_wr_addr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out)
    );

    // Power-on register contents, shared by the register-file model and the reference memory.
    function automatic logic [31:0] init_val(input logic [11:0] a);
        return a == 12'h000 ? 32'h2017_1108 : a == 12'h001 ? 32'h00D2_0006 : ({20'hA5C3E, a} ^ 32'h0F0F_0000);
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        bit chk;
`ifdef MPI_ADDR_RANGE_CHECK_EN
        chk = 1'b1;
`else
        chk = 1'b0;
`endif
        return chk && (a[31:14] != 18'd0);
    endfunction

    // Register-file model: data is valid only in the cycle RD_LAT after cpu_rd, garbage otherwise.
    logic [31:0]   mem [4096];
    logic [4095:0] wrote = '0;
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [31:0]   d1 = '0, d2 = '0;
    int            wr_cnt = 0, rd_cnt = 0;
    always @(posedge clks) begin
        if (cpu_wr) begin
            mem[cpu_wr_addr]   <= cpu_data_in;
            wrote[cpu_wr_addr] <= 1'b1;
        end
        v1     <= cpu_rd;
        d1     <= wrote[cpu_wr_addr] ? mem[cpu_wr_addr] : init_val(cpu_wr_addr);
        v2     <= v1;
        d2     <= d1;
        wr_cnt <= wr_cnt + int'(cpu_wr);
        rd_cnt <= rd_cnt + int'(cpu_rd);
    end
    assign cpu_data_out = v2 ? d2 : 32'hBAD0_0BAD;

    // Reference memory: what an ideal bridge would have written.
    logic [31:0] ref_mem [4096];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clks);
        reset_n   = 1'b0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
        repeat (2) @(negedge clks);
        check("rst_ctrl", 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cpu_wr, cpu_rd}), 32'd0);
        check("rst_addr", 32'(cpu_wr_addr), 32'd0);
        check("rst_wdata", cpu_data_in, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_resp", 32'({s_bresp, s_rresp}), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input bit rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clks);
            ok = rd ? s_arready : s_awready;
        end
        check(rd ? "ar_accept" : "aw_accept", 32'(ok), 32'd1);
    endtask

    // Called at the negedge of the accept cycle T.
    task automatic finish_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        bit ok;
        logic [1:0] resp;
        int c0;
        ok   = (s == 4'hF) && !addr_err(a);
        resp = ok ? 2'b00 : 2'b10;
        c0   = wr_cnt;
        check("wready", 32'(s_wready), 32'd1);
        @(negedge clks);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("cpu_wr", 32'(cpu_wr), 32'(ok));
        if (ok) begin
            check("wr_addr", 32'(cpu_wr_addr), 32'(a[13:2]));
            check("wr_data", cpu_data_in, d);
            ref_mem[a[13:2]] = d;
        end
        check("bvalid_early", 32'(s_bvalid), 32'd0);
        @(negedge clks);
        for (int i = 0; i <= hold; i++) begin
            check("bvalid", 32'(s_bvalid), 32'd1);
            check("bresp", 32'(s_bresp), 32'(resp));
            if (i < hold) begin
                check("no_accept_b", 32'({s_awready, s_arready}), 32'd0);
                @(negedge clks);
            end
        end
        s_bready = 1'b1;
        @(negedge clks);
        s_bready = 1'b0;
        check("bvalid_drop", 32'(s_bvalid), 32'd0);
        check("wr_pulses", 32'(wr_cnt - c0), 32'(ok));
    endtask

    task automatic finish_read(input logic [31:0] a, input int hold);
        bit err;
        logic [31:0] exp;
        int c0;
        err = addr_err(a);
        exp = err ? 32'd0 : ref_mem[a[13:2]];
        c0  = rd_cnt;
        @(negedge clks);
        s_arvalid = 1'b0;
        check("cpu_rd", 32'(cpu_rd), 32'(!err));
        if (!err) check("rd_addr", 32'(cpu_wr_addr), 32'(a[13:2]));
        for (int i = 0; i < RD_LAT; i++) begin
            @(negedge clks);
            check("rvalid_early", 32'(s_rvalid), 32'd0);
        end
        @(negedge clks);
        for (int i = 0; i <= hold; i++) begin
            check("rvalid", 32'(s_rvalid), 32'd1);
            check("rdata", s_rdata, exp);
            check("rresp", 32'(s_rresp), err ? 32'd2 : 32'd0);
            if (i < hold) begin
                check("no_accept_r", 32'({s_awready, s_arready}), 32'd0);
                @(negedge clks);
            end
        end
        s_rready = 1'b1;
        @(negedge clks);
        s_rready = 1'b0;
        check("rvalid_drop", 32'(s_rvalid), 32'd0);
        check("rd_pulses", 32'(rd_cnt - c0), 32'(!err));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        bit ok;
        @(negedge clks);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
        wait_ready(1'b0, ok);
        if (ok) finish_write(a, d, s, hold);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold);
        bit ok;
        @(negedge clks);
        s_araddr = a; s_arvalid = 1'b1;
        wait_ready(1'b1, ok);
        if (ok) finish_read(a, hold);
        s_arvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          h;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        do_reset();

        axi_write(32'h0000_0008, 32'h1234_5678, 4'hF, 0);
        axi_read(32'h0000_0004, 0);
        axi_write(32'h0000_0010, 32'h5555_AAAA, 4'h3, 1);

        // AW without W and W without AW must stay unaccepted.
        for (int k = 0; k < 2; k++) begin
            @(negedge clks);
            s_awvalid = (k == 0); s_wvalid = (k == 1);
            repeat (4) begin
                @(negedge clks);
                check("half_write", 32'({s_awready, s_wready, s_arready}), 32'd0);
            end
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end

        // Simultaneous AW/W/AR straight after reset: read first, then write with a stalled bready.
        do_reset();
        @(negedge clks);
        s_awaddr = 32'h0000_0020; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_araddr = 32'h0000_0004;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        wait_ready(1'b1, ok);
        if (ok) begin
            check("aw_not_first", 32'(s_awready), 32'd0);
            finish_read(32'h0000_0004, 0);
            wait_ready(1'b0, ok);
            if (ok) begin
                s_araddr = 32'h0000_0020; s_arvalid = 1'b1;
                finish_write(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 5);
                wait_ready(1'b1, ok);
                if (ok) finish_read(32'h0000_0020, 0);
            end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;

        // Out-of-window address: aliases to word 0, or SLVERR with the range check.
        axi_read(32'h0001_0000, 1);

        // Reset during RD_WAIT drops the read; the next read completes normally.
        @(negedge clks);
        s_araddr = 32'h0000_0008; s_arvalid = 1'b1;
        wait_ready(1'b1, ok);
        @(negedge clks);
        s_arvalid = 1'b0;
        @(negedge clks);
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({s_arready, s_rvalid, cpu_rd, cpu_wr}), 32'd0);
        check("midrst_addr", 32'(cpu_wr_addr), 32'd0);
        @(negedge clks);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clks);
            check("midrst_no_rvalid", 32'(s_rvalid), 32'd0);
        end
        axi_read(32'h0000_0008, 0);

        repeat (40) begin
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a[31:14] = 18'($urandom) | 18'd1;
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            h = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) axi_write(a, d, s, h);
            else axi_read(a, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mpi_axil_master.md
# mpi_axil_master

AXI4-Lite slave-side bridge that initiates transactions on the MPI register bus (cpu_wr / cpu_rd / cpu_wr_addr / cpu_data_in / cpu_data_out). It sits between the shell's AXI4-Lite user-register window and the user-logic register file, which decodes that bus. The block converts one AXI4-Lite access at a time into an MPI write or read, waits the register file's fixed read latency, and returns the AXI response.

## Interface
- CPU_ADDR_WIDTH, 12, MPI word-address width.
- CPU_DATA_WIDTH, 32, MPI/AXI data width; only 32 is supported, so the strobe is 4 bits.
- AXI_ADDR_WIDTH, 32, AXI byte-address width; must be ≥ CPU_ADDR_WIDTH+2.
- RD_LAT, 2, cycles from the cycle cpu_rd is high to the cycle cpu_data_out is sampled; legal range 1..15.

Ports:
- clks  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_awvalid, s_awready  in/out  1  write-address handshake.
- s_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- s_wvalid, s_wready  in/out  1  write-data handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes.
- s_bvalid  out  1, s_bready  in  1, s_bresp  out  2  write-response channel.
- s_arvalid, s_arready  in/out  1  read-address handshake.
- s_araddr  in  AXI_ADDR_WIDTH  read byte address.
- s_rvalid  out  1, s_rready  in  1, s_rdata  out  32, s_rresp  out  2  read-data channel.
- cpu_wr  out  1  one-cycle MPI write strobe.
- cpu_rd  out  1  one-cycle MPI read strobe.
- cpu_wr_addr  out  CPU_ADDR_WIDTH  MPI word address, shared by reads and writes.
- cpu_data_in  out  32  MPI write data.
- cpu_data_out  in  32  MPI read data.

## Operation
- Word address = axaddr[CPU_ADDR_WIDTH+1:2]; axaddr[1:0] are ignored.
- All outputs are registered.
- Reset values: every ready/valid/strobe output is 0; cpu_wr_addr, cpu_data_in, s_rdata and s_bresp/s_rresp are 0.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - A write is pending only when s_awvalid and s_wvalid are both high. AW without W (or W without AW) is left unaccepted.
  - A read is pending when s_arvalid is high.
  - If only one is pending, serve it.
  - If both are pending, serve the type not served last. The last-served flag resets to "write", so the first conflict after reset serves the read.
- Accept:
  - Write: assert s_awready and s_wready for exactly one cycle, together; latch the address, data and strobe.
  - Read: assert s_arready for one cycle; latch the address.
- WR_ISSUE:
  - If s_wstrb is 4'hF, cpu_wr=1 for one cycle with cpu_wr_addr/cpu_data_in driven; bresp=OKAY.
  - Otherwise no cpu_wr is issued and bresp=SLVERR (2'b10).
- WR_RESP: s_bvalid=1, held with stable s_bresp until s_bready; then go to IDLE.
- RD_ISSUE: cpu_rd=1 for one cycle with cpu_wr_addr driven. RD_WAIT then counts RD_LAT cycles.
- RD_WAIT: on the edge ending the last wait cycle, capture cpu_data_out into s_rdata; rresp=OKAY.
- RD_RESP: s_rvalid=1, held with s_rdata/s_rresp stable until s_rready; then go to IDLE.
- cpu_wr_addr holds its last value between transactions and never changes while a read is outstanding, because the register file decodes it continuously.
- Reset asserted mid-transaction:
  - All state returns to IDLE immediately with outputs at their reset values.
  - The in-flight transaction is dropped and no response is issued.

## Timing
- Write:
  - Accept in cycle T.
  - cpu_wr high in T+1.
  - s_bvalid high from T+2.
  - Next accept no earlier than the cycle after the b handshake.
- Read:
  - Accept in cycle T.
  - cpu_rd high in T+1.
  - Sample at the end of cycle T+1+RD_LAT.
  - s_rvalid high from T+2+RD_LAT (T+4 at the default).
- Throughput: at most one outstanding transaction; there is no pipelining.
- A response held against a stalled bready/rready blocks all new accepts.

## Configuration
- MPI_ADDR_RANGE_CHECK_EN defined:
  - If any byte-address bit above CPU_ADDR_WIDTH+1 is nonzero, the access issues no cpu_wr/cpu_rd.
  - It is answered with SLVERR, s_rdata=0, with the same cycle timing as a normal access.
- MPI_ADDR_RANGE_CHECK_EN undefined: upper address bits are ignored, so the address aliases onto the MPI space.

## Test plan
- Write 0x0000_0008 / data 0x1234_5678 / wstrb 4'hF -> cpu_wr pulses once with cpu_wr_addr=12'h002 and cpu_data_in=0x12345678; bresp=OKAY at T+2.
- Read 0x0000_0004 with the register file returning 0x00D2_0006 at address 1 -> cpu_rd pulse at T+1; s_rdata=0x00D20006 and s_rvalid at T+4.
- Write with wstrb 4'h3 -> no cpu_wr pulse, bresp=SLVERR.
- AW, W and AR all valid in the same cycle right after reset -> read served first, then write; hold bready=0 for 5 cycles -> bvalid and bresp remain stable and no new accept occurs.
- Read 0x0001_0000 -> with the macro: no cpu_rd, rresp=SLVERR, rdata=0; without the macro: a cpu_rd at address 12'h000 returning 0x2017_1108.
- Deassert reset_n during RD_WAIT -> no s_rvalid; the next read after reset completes normally.
